// File: rtl/mips_pkg.sv
// Shared MIPS III core types: exception cause codes and the EX/MEM slot payload.
package mips_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned REGW = 5;

   typedef enum logic [4:0] {
      EXC_NONE = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_OV   = 5'd12,
      EXC_TR   = 5'd13
   } exc_code_t;

   typedef struct packed {
      logic              mem_read;
      logic              mem_write;
      logic              mem_half;
      logic              mem_byte;
      logic              mem_sign_extend;
      logic              reg_write;
      logic              mem_to_reg;
      logic              llsc;
      logic [XLEN-1:0]   alu_result;
      logic [XLEN-1:0]   write_data;
      logic [REGW-1:0]   reg_dst;
      logic              exc_valid;
      exc_code_t         exc_code;
      logic [XLEN-1:0]   epc;
      logic [XLEN-1:0]   bad_vaddr;
      logic              sc_success;
   } exmem_slot_t;

endpackage

// File: rtl/ex_exc_detect.sv
// Execute-phase exception detection: overflow, conditional trap, address misalignment.
module ex_exc_detect
   import mips_pkg::*;
(
   input  logic            trap,
   input  logic            trap_cond,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            mem_half,
   input  logic            mem_byte,
   input  logic            exc_ov,
   input  logic [XLEN-1:0] alu_result,
   output logic            exc_c,
   output exc_code_t       exc_code_c
);

   logic trap_hit;
   logic misaligned;

   always_comb begin
      trap_hit   = trap && ((alu_result != '0) == trap_cond);
      misaligned = 1'b0;
      if (mem_read || mem_write) begin
         if (mem_half)
            misaligned = alu_result[0];
         else if (!mem_byte)
            misaligned = (alu_result[1:0] != 2'b00);
      end
   end

   // Overflow outranks trap, which outranks address errors.
   always_comb begin
      exc_c      = 1'b0;
      exc_code_c = EXC_NONE;
      if (exc_ov) begin
         exc_c      = 1'b1;
         exc_code_c = EXC_OV;
      end else if (trap_hit) begin
         exc_c      = 1'b1;
         exc_code_c = EXC_TR;
      end else if (misaligned) begin
         exc_c      = 1'b1;
         exc_code_c = mem_read ? EXC_ADEL : EXC_ADES;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with exception suppression and the LL/SC link bit.
module ex_mem_stage
   import mips_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Stall,
   input  logic            Flush,
   input  logic            Trap,
   input  logic            TrapCond,
   input  logic            LLSC,
   input  logic            MemRead,
   input  logic            MemWrite,
   input  logic            MemHalf,
   input  logic            MemByte,
   input  logic            MemSignExtend,
   input  logic            RegWrite,
   input  logic            MemtoReg,
   input  logic [31:0]     ALUResult,
   input  logic [31:0]     ReadData2,
   input  logic [4:0]      RegDstOut,
   input  logic            ExcOv,
   input  logic [31:0]     ExPC,
   output logic            MemRead_o,
   output logic            MemWrite_o,
   output logic            MemHalf_o,
   output logic            MemByte_o,
   output logic            MemSignExtend_o,
   output logic            RegWrite_o,
   output logic            MemtoReg_o,
   output logic            LLSC_o,
   output logic [31:0]     ALUResult_o,
   output logic [31:0]     WriteData_o,
   output logic [4:0]      RegDstOut_o,
   output logic            ExcValid,
   output logic [4:0]      ExcCode,
   output logic [31:0]     EPC,
   output logic [31:0]     BadVAddr,
   output logic            LLBit,
   output logic            SCSuccess
);

   exmem_slot_t slot_q, slot_d, cap;
   logic        ll_bit_q, ll_bit_d;
   logic        exc;
   exc_code_t   exc_code;
   logic        is_sc, is_ll, addr_err;

   ex_exc_detect u_exc_detect (
      .trap       (Trap),
      .trap_cond  (TrapCond),
      .mem_read   (MemRead),
      .mem_write  (MemWrite),
      .mem_half   (MemHalf),
      .mem_byte   (MemByte),
      .exc_ov     (ExcOv),
      .alu_result (ALUResult),
      .exc_c      (exc),
      .exc_code_c (exc_code)
   );

   // Slot contents if the EX bundle is captured this edge.
   always_comb begin
      is_sc    = LLSC && MemWrite;
      is_ll    = LLSC && MemRead;
      addr_err = (exc_code == EXC_ADEL) || (exc_code == EXC_ADES);

      cap                 = '0;
      cap.mem_read        = MemRead && !exc;
      cap.mem_write       = MemWrite && !exc;
      cap.mem_half        = MemHalf;
      cap.mem_byte        = MemByte;
      cap.mem_sign_extend = MemSignExtend;
      cap.reg_write       = RegWrite && !exc;
      cap.mem_to_reg      = MemtoReg;
      cap.llsc            = LLSC;
      cap.alu_result      = ALUResult;
      cap.write_data      = ReadData2;
      cap.reg_dst         = RegDstOut;
      cap.exc_valid       = exc;
      cap.exc_code        = exc_code;
      cap.epc             = ExPC;
      cap.bad_vaddr       = addr_err ? ALUResult : '0;
      cap.sc_success      = 1'b0;

      // SC stores only while the link holds; rt receives the success flag, not memory.
      if (is_sc && !exc) begin
         cap.mem_write  = ll_bit_q;
         cap.sc_success = ll_bit_q;
         cap.mem_to_reg = 1'b0;
      end
   end

   always_comb begin
      slot_d   = slot_q;
      ll_bit_d = ll_bit_q;
      if (Flush) begin
         slot_d   = '0;
         ll_bit_d = 1'b0;
      end else if (!Stall) begin
         slot_d = cap;
         if (is_sc)
            ll_bit_d = 1'b0;
         else if (is_ll && !exc)
            ll_bit_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q   <= '0;
         ll_bit_q <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         ll_bit_q <= ll_bit_d;
      end
   end

   assign MemRead_o       = slot_q.mem_read;
   assign MemWrite_o      = slot_q.mem_write;
   assign MemHalf_o       = slot_q.mem_half;
   assign MemByte_o       = slot_q.mem_byte;
   assign MemSignExtend_o = slot_q.mem_sign_extend;
   assign RegWrite_o      = slot_q.reg_write;
   assign MemtoReg_o      = slot_q.mem_to_reg;
   assign LLSC_o          = slot_q.llsc;
   assign ALUResult_o     = slot_q.alu_result;
   assign WriteData_o     = slot_q.write_data;
   assign RegDstOut_o     = slot_q.reg_dst;
   assign ExcValid        = slot_q.exc_valid;
   assign ExcCode         = slot_q.exc_code;
   assign EPC             = slot_q.epc;
   assign BadVAddr        = slot_q.bad_vaddr;
   assign SCSuccess       = slot_q.sc_success;
   assign LLBit           = ll_bit_q;

endmodule
